// File: rtl/mem_word_arbiter.sv
// mem_word_arbiter: round-robin arbiter serialising 16-bit word accesses from two ports onto a byte-wide memory.
// Each word takes four cycles after the grant: high byte, low byte, read tail, then the ack.
module mem_word_arbiter #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r1_req,
    input  logic              r0_we,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [15:0]       r0_wdata,
    input  logic [15:0]       r1_wdata,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic              owner,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    if (LAT != 1) begin : g_lat_unsupported
        $error("mem_word_arbiter supports only LAT=1");
    end

    typedef enum logic [2:0] {IDLE, HI, LO, TAIL, ACK} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              grant;
    logic [ADDR_W-1:0] addr_lo;

    // On a tie the port not granted last wins; a lone requester always wins.
    assign grant   = (r0_req && r1_req) ? ~last_q : r1_req;
    assign addr_lo = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (r0_req || r1_req) begin
                state_d = HI;
                owner_d = grant;
                last_d  = grant;
                we_d    = grant ? r1_we : r0_we;
                addr_d  = grant ? r1_addr : r0_addr;
                wdata_d = grant ? r1_wdata : r0_wdata;
            end
            HI:      state_d = LO;
            LO:      state_d = TAIL;
            TAIL:    state_d = ACK;
            default: state_d = IDLE;
        endcase
        // Memory data lags the address by one cycle, so each byte lands one state later.
        if (state_q == LO && !we_q) rdata_d[15:8] = mem_rdata;
        if (state_q == TAIL && !we_q) rdata_d[7:0] = mem_rdata;
    end

    assign busy      = state_q != IDLE;
    assign owner     = owner_q;
    assign rdata     = rdata_q;
    assign r0_ack    = state_q == ACK && !owner_q;
    assign r1_ack    = state_q == ACK && owner_q;
    assign mem_addr  = state_q == HI ? addr_q : state_q == LO ? addr_lo : '0;
    assign mem_we    = we_q && (state_q == HI || state_q == LO);
    assign mem_wdata = !we_q ? 8'h00 : state_q == HI ? wdata_q[15:8] : state_q == LO ? wdata_q[7:0] : 8'h00;
endmodule

// File: tb/tb_mem_word_arbiter.sv
// tb_mem_word_arbiter: directed checks of word sequencing, wrap, round-robin and reset abort.
module tb_mem_word_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0, r0_we = 1'b0, r1_we = 1'b0;
    logic [7:0]  r0_addr = '0, r1_addr = '0;
    logic [15:0] r0_wdata = '0, r1_wdata = '0;
    logic        r0_ack, r1_ack, busy, owner, mem_we;
    logic [15:0] rdata;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic [7:0]  mem [256];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    mem_word_arbiter #(.ADDR_W(8), .LAT(1)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_ack(r0_ack), .r1_ack(r1_ack), .rdata(rdata), .busy(busy), .owner(owner),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Byte memory with one-cycle read latency; read happens before the write.
    always @(posedge clock) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one request on port p and checks every cycle up to the ack; req is dropped at cycle 'drop'.
    task automatic txn(input logic p, input logic we, input logic [7:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input int drop);
        logic [7:0] a1;
        a1 = a + 8'd1;
        if (p) begin r1_req = 1; r1_we = we; r1_addr = a; r1_wdata = wd; end
        else   begin r0_req = 1; r0_we = we; r0_addr = a; r0_wdata = wd; end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            case (c)
                1: begin
                    check("hi_busy", busy, 1);
                    check("hi_owner", owner, p);
                    check("hi_addr", mem_addr, a);
                    check("hi_we", mem_we, we);
                    if (we) check("hi_wdata", mem_wdata, wd[15:8]);
                end
                2: begin
                    check("lo_addr", mem_addr, a1);
                    check("lo_we", mem_we, we);
                    if (we) check("lo_wdata", mem_wdata, wd[7:0]);
                end
                3: check("tail_we", mem_we, 0);
                default: begin
                    check("ack_own", p ? r1_ack : r0_ack, 1);
                    check("ack_other", p ? r0_ack : r1_ack, 0);
                    check("ack_rdata", rdata, exp_rd);
                    check("ack_memwe", mem_we, 0);
                    check("ack_addr", mem_addr, 0);
                end
            endcase
            if (c == drop) begin
                if (p) r1_req = 0; else r0_req = 0;
            end
        end
        if (p) r1_req = 0; else r0_req = 0;
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_acks", {r0_ack, r1_ack}, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h14] = 8'h10; mem[8'h15] = 8'h04;
        mem[8'hFF] = 8'hAB; mem[8'h00] = 8'hCD;
        #12;
        check("rst_busy", busy, 0);
        check("rst_memwe", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        check("rst_acks", {r0_ack, r1_ack}, 0);
        check("rst_owner", owner, 0);
        @(negedge clock);
        reset = 0;
        txn(0, 0, 8'h14, 16'h0000, 16'h1004, 1);
        txn(1, 1, 8'h12, 16'h0041, 16'h1004, 1);
        check("wr_hi_byte", mem[8'h12], 8'h00);
        check("wr_lo_byte", mem[8'h13], 8'h41);
        txn(0, 0, 8'hFF, 16'h0000, 16'hABCD, 1);
        txn(0, 0, 8'h12, 16'h0000, 16'h0041, 2);

        reset = 1;
        @(negedge clock);
        reset = 0;
        r1_req = 1; r1_we = 0; r1_addr = 8'h14;
        txn(0, 0, 8'hFF, 16'h0000, 16'hABCD, 1);
        check("rr_r1_waiting", r1_req, 1);
        txn(1, 0, 8'h14, 16'h0000, 16'h1004, 1);
        r1_req = 1; r1_we = 0; r1_addr = 8'h14;
        txn(0, 0, 8'h12, 16'h0000, 16'h0041, 1);
        r1_req = 0;

        r0_req = 1; r0_we = 1; r0_addr = 8'h20; r0_wdata = 16'hBEEF;
        @(negedge clock);
        check("abort_hi_we", mem_we, 1);
        r0_req = 0;
        @(negedge clock);
        check("abort_lo_we", mem_we, 1);
        reset = 1;
        #1;
        check("abort_memwe", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_rdata", rdata, 0);
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("abort_noack", {r0_ack, r1_ack, busy}, 0);
        end
        check("abort_hi_written", mem[8'h20], 8'hBE);
        check("abort_lo_untouched", mem[8'h21], 8'h00);
        txn(0, 0, 8'h14, 16'h0000, 16'h1004, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mem_word_arbiter.md
MEM_WORD_ARBITER -- requirements
Module: mem_word_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width of the shared memory.
REQ-002 SHALL have parameter LAT, default 1, read latency of the memory in cycles; only 1 is supported.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have ports r0_req / r1_req, input, 1, word-access request from port 0 (CPU) / port 1 (loader).
REQ-006 SHALL have ports r0_we / r1_we, input, 1, 1 = write word, 0 = read word.
REQ-007 SHALL have ports r0_addr / r1_addr, input, ADDR_W, byte address of the word's high byte.
REQ-008 SHALL have ports r0_wdata / r1_wdata, input, 16, write word.
REQ-009 SHALL have ports r0_ack / r1_ack, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, 16, read word, shared by both ports.
REQ-011 SHALL have port busy, output, 1, high while a transaction is in progress.
REQ-012 SHALL have port owner, output, 1, index of the granted port; valid while busy.
REQ-013 SHALL have port mem_addr, output, ADDR_W, byte address to memory.
REQ-014 SHALL have port mem_we, output, 1, byte write strobe.
REQ-015 SHALL have port mem_wdata, output, 8, byte write data.
REQ-016 SHALL have port mem_rdata, input, 8, byte read data, valid one cycle after mem_addr is presented.

Function
REQ-017 SHALL implement FSM states IDLE, HI, LO, TAIL, ACK; the transitions are IDLE->HI on grant, then HI->LO->TAIL->ACK->IDLE unconditionally.
REQ-018 SHALL, in IDLE, grant at the clock edge where any req is high; it latches the owner's we, addr and wdata at that edge.
REQ-019 SHALL arbitrate round-robin: a lone requester wins; when both request, the port not granted last wins; the last-grant register resets to 1, so port 0 wins the first tie.
REQ-020 SHALL, in HI, drive mem_addr=addr; when we=1 it also drives mem_we=1 and mem_wdata=wdata[15:8].
REQ-021 SHALL, in LO, drive mem_addr=addr+1, modulo 2^ADDR_W (0xFF wraps to 0x00); when we=1 it also drives mem_we=1 and mem_wdata=wdata[7:0].
REQ-022 SHALL, for reads, capture mem_rdata into rdata[15:8] at the edge ending LO and into rdata[7:0] at the edge ending TAIL.
REQ-023 SHALL, in TAIL, drive mem_we=0 for both reads and writes; latency is fixed for both.
REQ-024 SHALL, in ACK, assert the owner's ack for exactly one cycle and hold the other port's ack low; for reads, rdata is valid in ACK and holds until the next read capture.
REQ-025 SHALL give a fixed latency: ack is high in the 4th cycle after the grant edge.
REQ-026 SHALL keep rdata unchanged on writes.
REQ-027 SHALL ignore req and all request inputs outside IDLE; deasserting req mid-transaction does not abort it, and ack still pulses.
REQ-028 SHALL require the requester to drop req in the cycle after ack; a req still high when IDLE is re-entered is treated as a new request.
REQ-029 SHALL drive busy=1 in HI, LO, TAIL and ACK, and busy=0 in IDLE.
REQ-030 SHALL drive mem_we=0 and mem_addr=0 in IDLE and ACK.
REQ-031 SHALL form big-endian words: high byte at addr, low byte at addr+1.

Reset
REQ-032 SHALL, while reset is high, immediately (asynchronously) set state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, r0_ack=r1_ack=0, rdata=0, busy=0, owner=0 and last-grant=1.
REQ-033 SHALL, on reset mid-transaction, abandon the transaction with no ack; a write interrupted after HI may leave only its high byte written, and this is accepted behaviour.

Verification
REQ-034 SHALL pass: MEM[0x14]=0x10, MEM[0x15]=0x04; r0 read at 0x14 -> mem_addr 0x14 then 0x15; r0_ack in 4th cycle; rdata=0x1004.
REQ-035 SHALL pass: r1 write of 0x0041 at 0x12 -> mem_we high 2 cycles; 0x00@0x12, then 0x41@0x13; r1_ack pulses; rdata unchanged.
REQ-036 SHALL pass: r0 read at 0xFF with MEM[0xFF]=0xAB, MEM[0x00]=0xCD -> second byte from 0x00; rdata=0xABCD.
REQ-037 SHALL pass: both req high after reset -> port 0 served first, then port 1; both high again -> port 0; acks never overlap.
REQ-038 SHALL pass: reset pulsed during LO of a write -> mem_we low immediately; busy=0; no ack; next request is served normally.
REQ-039 SHALL pass: r0_req dropped in LO of a read -> transaction completes and r0_ack still pulses with correct rdata.
